// File: rtl/addr_strobe_fifo_pkg.sv
// Shared defaults and sizing helpers for the address strobe capture FIFO.
package addr_strobe_fifo_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 16;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/addr_strobe_fifo_if.sv
// Bus-side and status signals of the address strobe capture FIFO.
interface addr_strobe_fifo_if
  import addr_strobe_fifo_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] bus_addr;
  logic          bus_strobe;
  logic          pop_req;
  logic          clr_ovf;
  logic [AW-1:0] addr_out;
  logic          valid;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output bus_addr, bus_strobe, pop_req, clr_ovf,
    input  addr_out, valid, count, overflow
  );

  modport slave (
    input  bus_addr, bus_strobe, pop_req, clr_ovf,
    output addr_out, valid, count, overflow
  );

endinterface

// File: rtl/addr_strobe_fifo_addr_fifo.sv
// Circular address store with first-word-fall-through read; count alone
// separates full from empty since both pointers wrap modulo DEPTH.
module addr_fifo
  import addr_strobe_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [AW-1:0]           din,
  output logic [AW-1:0]           dout,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd_en;
  logic          wr_en;

  // A pop on an empty store is ignored; a push into a full store only
  // proceeds when the head leaves in the same cycle.
  assign rd_en = pop && (count != '0);
  assign wr_en = push && ((count != FULL) || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/addr_strobe_fifo.sv
// Captures bus_addr on each bus_strobe rising edge into a small FIFO,
// popped by pop_req edges, with a sticky overflow flag cleared by clr_ovf edges.
module addr_strobe_fifo
  import addr_strobe_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  addr_strobe_fifo_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          strobe_p0;
  logic          pop_p0;
  logic          clr_p0;
  logic          push_edge;
  logic          pop_edge;
  logic          clr_edge;
  logic          ovf_event;
  logic          overflow;
  logic [AW-1:0] dout;
  logic [CW-1:0] count;

  // Stage p0: previous level of each control input, cleared by reset so a
  // level still high at release reads as a fresh edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_p0 <= 1'b0;
      pop_p0    <= 1'b0;
      clr_p0    <= 1'b0;
    end else begin
      strobe_p0 <= bus.bus_strobe;
      pop_p0    <= bus.pop_req;
      clr_p0    <= bus.clr_ovf;
    end
  end

  assign push_edge = bus.bus_strobe & ~strobe_p0;
  assign pop_edge  = bus.pop_req    & ~pop_p0;
  assign clr_edge  = bus.clr_ovf    & ~clr_p0;

  // A full store with a concurrent pop makes room, so only an unpaired push drops.
  assign ovf_event = push_edge && (count == FULL) && !pop_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (clr_edge) begin
      overflow <= 1'b0;
    end
  end

  addr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_edge),
    .pop     (pop_edge),
    .din     (bus.bus_addr),
    .dout    (dout),
    .count   (count)
  );

  assign bus.addr_out = dout;
  assign bus.count    = count;
  assign bus.valid    = (count != '0);
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_addr_strobe_fifo.sv
// Scoreboard bench for addr_strobe_fifo: a queue-based reference model
// predicts every cycle; a negedge monitor compares the DUT against it.
module tb_addr_strobe_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  addr_strobe_fifo_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  addr_strobe_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int      cnt;
    bit      vld;
    int      head;
    bit      ovf;
  } exp_t;

  exp_t exp_q[$];
  int   model_q[$];
  bit   m_ovf;
  bit   prev_s, prev_p, prev_c;
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: each negedge after a stimulus cycle is compared to its prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count",    int'(bus.count),    e.cnt);
      chk("valid",    int'(bus.valid),    int'(e.vld));
      chk("addr_out", int'(bus.addr_out), e.head);
      chk("overflow", int'(bus.overflow), int'(e.ovf));
    end
  end

  // Drive one cycle of input levels and predict the state after the next edge.
  task automatic step(input bit s, input bit p, input bit c, input logic [AW-1:0] a);
    bit se, pe, ce, drop;
    exp_t e;
    bus.bus_strobe = s;
    bus.pop_req    = p;
    bus.clr_ovf    = c;
    bus.bus_addr   = a;
    se = s && !prev_s;
    pe = p && !prev_p;
    ce = c && !prev_c;
    prev_s = s;
    prev_p = p;
    prev_c = c;
    drop = 1'b0;
    if (pe && model_q.size() > 0) void'(model_q.pop_front());
    if (se) begin
      if (model_q.size() < DEPTH) model_q.push_back(int'(a));
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ce) m_ovf = 1'b0;
    e.cnt  = model_q.size();
    e.vld  = (model_q.size() > 0);
    e.head = (model_q.size() > 0) ? model_q[0] : 0;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Assert reset between edges, check the outputs clear at once, release a cycle later.
  task automatic do_reset(input bit s);
    @(negedge clk);
    #1;
    bus.bus_strobe = s;
    bus.pop_req    = 1'b0;
    bus.clr_ovf    = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_count",    int'(bus.count),    0);
    chk("rst_valid",    int'(bus.valid),    0);
    chk("rst_addr_out", int'(bus.addr_out), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    model_q.delete();
    m_ovf  = 1'b0;
    prev_s = 1'b0;
    prev_p = 1'b0;
    prev_c = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.bus_addr   = '0;
    bus.bus_strobe = 1'b0;
    bus.pop_req    = 1'b0;
    bus.clr_ovf    = 1'b0;
    do_reset(1'b0);

    // Two captures, then pops down to empty and one ignored pop.
    step(1, 0, 0, 16'h0100);
    settle();
    chk("first_capture", int'(bus.addr_out), 'h0100);
    step(0, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h0150);
    settle();
    chk("two_count", int'(bus.count), 2);
    chk("two_head",  int'(bus.addr_out), 'h0100);
    step(0, 1, 0, 16'h0000);
    settle();
    chk("pop1_head", int'(bus.addr_out), 'h0150);
    step(0, 0, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    settle();
    chk("pop2_valid", int'(bus.valid), 0);
    chk("pop2_head",  int'(bus.addr_out), 0);
    step(0, 0, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);

    // Nine strobes into eight slots, then drain in order.
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 16'hFF00 + 16'(i));
      step(0, 0, 0, 16'h0000);
    end
    settle();
    chk("fill_count", int'(bus.count), 8);
    chk("fill_ovf",   int'(bus.overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", int'(bus.addr_out), 'hFF00 + i);
      step(0, 1, 0, 16'h0000);
      step(0, 0, 0, 16'h0000);
      settle();
    end
    step(0, 0, 1, 16'h0000);
    step(0, 0, 0, 16'h0000);

    // Full store with push and pop on the same edge.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 16'h2000 + 16'(i));
      step(0, 0, 0, 16'h0000);
    end
    step(1, 1, 0, 16'h1234);
    settle();
    chk("swap_count", int'(bus.count), 8);
    chk("swap_ovf",   int'(bus.overflow), 0);
    step(0, 0, 0, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 16'h0000);
      step(0, 0, 0, 16'h0000);
    end
    settle();
    chk("swap_tail", int'(bus.addr_out), 'h1234);

    // Clear coinciding with a dropped push keeps overflow; a lone clear drops it.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 16'h3000 + 16'(i));
      step(0, 0, 0, 16'h0000);
    end
    step(1, 0, 1, 16'h9999);
    settle();
    chk("clr_vs_drop", int'(bus.overflow), 1);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 1, 16'h0000);
    settle();
    chk("clr_alone", int'(bus.overflow), 0);
    step(0, 0, 0, 16'h0000);

    // Reset mid-operation with the strobe held high across release.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 16'h4000 + 16'(i));
      step(0, 0, 0, 16'h0000);
    end
    do_reset(1'b1);
    step(1, 0, 0, 16'hABCD);
    settle();
    chk("post_rst_count", int'(bus.count), 1);
    chk("post_rst_head",  int'(bus.addr_out), 'hABCD);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset(1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addr_strobe_fifo.md
ADDR_STROBE_FIFO -- requirements
Module: addr_strobe_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; power of two, 2..64.
REQ-002 Parameter AW, default 16, captured address width.
REQ-003 Port clk, input, 1, single system clock; all logic is rising-edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port bus_addr, input, AW, address bus to capture; synchronous to clk.
REQ-006 Port bus_strobe, input, 1, level strobe; a rising edge marks one access to capture.
REQ-007 Port pop_req, input, 1, level driven by a software output port; a rising edge pops the head entry.
REQ-008 Port clr_ovf, input, 1, level; a rising edge clears the overflow flag.
REQ-009 Port addr_out, output, AW, head entry; drives the 16-bit address input port of the downstream port block.
REQ-010 Port valid, output, 1, FIFO non-empty.
REQ-011 Port count, output, $clog2(DEPTH+1), current occupancy.
REQ-012 Port overflow, output, 1, sticky flag; set when a capture was dropped.

Function
REQ-013 The block SHALL register bus_strobe, pop_req and clr_ovf once each and detect a rising edge as current=1 and previous=0.
REQ-014 A strobe edge in cycle N SHALL write bus_addr as sampled in cycle N; valid, count and addr_out SHALL reflect it from cycle N+1.
REQ-015 The FIFO SHALL be first-word-fall-through: addr_out equals the oldest entry whenever valid=1.
REQ-016 addr_out SHALL read 0 whenever valid=0.
REQ-017 A pop edge with valid=1 SHALL advance the head; the next entry, or 0 if the FIFO is now empty, SHALL appear on addr_out in the following cycle.
REQ-018 A pop edge with valid=0 SHALL be ignored, with no state change.
REQ-019 A push with count=DEPTH and no pop in the same cycle SHALL drop the new address, leave contents unchanged and set overflow.
REQ-020 Simultaneous push and pop with count=DEPTH SHALL pop and push, leave count at DEPTH and not set overflow.
REQ-021 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-022 Simultaneous push and pop with count=0 SHALL push only; the pop is ignored.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count alone SHALL distinguish full from empty.
REQ-024 A clr_ovf edge SHALL clear overflow; if an overflow event occurs in the same cycle, overflow SHALL remain set.
REQ-025 Outputs SHALL be registered or derived only from registered state, with no combinational path from inputs to outputs.

Reset
REQ-026 reset_n low SHALL immediately force count=0, valid=0, addr_out=0, overflow=0, pointers=0, and all edge-detect registers to 0.
REQ-027 Reset mid-operation SHALL discard all entries; stored RAM contents need not be cleared.
REQ-028 If a strobe, pop_req or clr_ovf level is high when reset releases, it SHALL count as a rising edge on the first clock after release.

Structure
REQ-029 A shared package SHALL hold the DEPTH and AW defaults and a count-width function; the FIFO state needs no typedef.
REQ-030 The storage and pointers SHALL be a sub-module addr_fifo (push, pop, din, dout, count); edge detection and overflow logic SHALL stay in the top module.

Verification
REQ-031 Reset, then strobe edges with bus_addr 0x0100 and 0x0150 -> count=2, valid=1, addr_out=0x0100 one cycle after the first edge.
REQ-032 From REQ-031, two pop edges -> addr_out=0x0150, then 0 with valid=0; a third pop edge -> no change.
REQ-033 DEPTH=8: nine strobes with 0xFF00..0xFF08 -> count=8, overflow=1; pop all entries -> 0xFF00..0xFF07 in order.
REQ-034 Full FIFO, strobe edge and pop edge in the same cycle with bus_addr 0x1234 -> count=8, overflow=0, 0x1234 at the tail.
REQ-035 Overflow set, clr_ovf edge in the same cycle as a new dropped push -> overflow stays 1; a clr_ovf edge alone next -> overflow=0.
REQ-036 Three entries stored, reset_n pulsed low for one cycle with bus_strobe held high -> all outputs 0 immediately; one entry captured after release.
